// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory read port shared by the fetch unit and memory.
// Fetch unit is master; memory answers with Ready/Data.
interface instruction_fetch_unit_if;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Ready;
    logic [31:0] IMem_Data;

    modport master (
        output IMem_Req,
        output IMem_Addr,
        input  IMem_Ready,
        input  IMem_Data
    );

    modport slave (
        input  IMem_Req,
        input  IMem_Addr,
        output IMem_Ready,
        output IMem_Data
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC, FETCH/HOLD control, one-entry hold buffer.
// All outputs (including IMem_Req/IMem_Addr) come straight from flops.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                            Clk,
    input  logic                            Reset_n,
    input  logic                            Stall,
    input  logic                            Branch_Taken,
    input  logic [31:0]                     Branch_Target,
    instruction_fetch_unit_if.master        imem,
    output logic [31:0]                     Instruction_out,
    output logic [31:0]                     PC_Plus_4_out,
    output logic                            Fetch_Valid,
    output logic                            FlushRegisters
);

    typedef enum logic {FETCH, HOLD} state_t;

    localparam logic [31:0] PC_INIT = RESET_PC & 32'hFFFF_FFFC;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        flush_q, flush_d;
    logic [31:0] hb_instr_q, hb_instr_d;
    logic [31:0] hb_pc4_q, hb_pc4_d;
    logic [31:0] pc_plus4;
    logic        rdy;

    assign pc_plus4 = pc_q + 32'd4;
    // Ready only counts while a request is actually out
    assign rdy      = imem.IMem_Ready & req_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        hb_instr_d = hb_instr_q;
        hb_pc4_d   = hb_pc4_q;
        flush_d    = Branch_Taken;
        if (Branch_Taken) begin
            state_d    = FETCH;
            pc_d       = Branch_Target & 32'hFFFF_FFFC;
            instr_d    = '0;
            pc4_d      = '0;
            valid_d    = 1'b0;
            hb_instr_d = '0;
            hb_pc4_d   = '0;
        end else if (state_q == FETCH) begin
            unique case (1'b1)
                rdy && !Stall: begin
                    instr_d = imem.IMem_Data;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                    pc_d    = pc_plus4;
                end
                !rdy && !Stall: begin
                    instr_d = '0;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end
                rdy && Stall: begin
                    hb_instr_d = imem.IMem_Data;
                    hb_pc4_d   = pc_plus4;
                    pc_d       = pc_plus4;
                    state_d    = HOLD;
                end
                default: ;
            endcase
        end else if (!Stall) begin
            instr_d = hb_instr_q;
            pc4_d   = hb_pc4_q;
            valid_d = 1'b1;
            state_d = FETCH;
        end
        req_d = (state_d == FETCH);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= FETCH;
            req_q      <= 1'b0;
            pc_q       <= PC_INIT;
            instr_q    <= '0;
            pc4_q      <= '0;
            valid_q    <= 1'b0;
            flush_q    <= 1'b0;
            hb_instr_q <= '0;
            hb_pc4_q   <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
            flush_q    <= flush_d;
            hb_instr_q <= hb_instr_d;
            hb_pc4_q   <= hb_pc4_d;
        end
    end

    assign imem.IMem_Req  = req_q;
    assign imem.IMem_Addr = pc_q;
    assign Instruction_out = instr_q;
    assign PC_Plus_4_out   = pc4_q;
    assign Fetch_Valid     = valid_q;
    assign FlushRegisters  = flush_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: memory returns word = address,
// deliveries checked through an expected-value queue.
module tb_instruction_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Stall;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic        mem_ready;

    logic [31:0] instr, pc4, instr_w, pc4_w;
    logic        valid, flush, valid_w, flush_w;

    instruction_fetch_unit_if bus ();
    instruction_fetch_unit_if bus_w ();

    assign bus.IMem_Ready   = mem_ready;
    assign bus.IMem_Data    = bus.IMem_Addr;
    assign bus_w.IMem_Ready = mem_ready;
    assign bus_w.IMem_Data  = bus_w.IMem_Addr;

    instruction_fetch_unit dut (
        .Clk(Clk), .Reset_n(Reset_n), .Stall(Stall),
        .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
        .imem(bus),
        .Instruction_out(instr), .PC_Plus_4_out(pc4),
        .Fetch_Valid(valid), .FlushRegisters(flush)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .Clk(Clk), .Reset_n(Reset_n), .Stall(Stall),
        .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
        .imem(bus_w),
        .Instruction_out(instr_w), .PC_Plus_4_out(pc4_w),
        .Fetch_Valid(valid_w), .FlushRegisters(flush_w)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] e;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        Stall = 1'b0;
        Branch_Taken = 1'b0;
        Branch_Target = '0;
        mem_ready = 1'b1;
        exp_q.delete();
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        Stall = 1'b0;
        Branch_Taken = 1'b0;
        Branch_Target = '0;
        mem_ready = 1'b1;
        #2;
        n_tests++;
        if ({bus.IMem_Req, valid, flush, instr, pc4} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got req=%b v=%b f=%b i=%h p=%h want all 0",
                     bus.IMem_Req, valid, flush, instr, pc4);
        end
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        step();
        n_tests++;
        if (bus.IMem_Req !== 1'b1 || bus.IMem_Addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_first_req got req=%b addr=%h want 1 00000000",
                     bus.IMem_Req, bus.IMem_Addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] m_pc;
        do_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({m_pc, m_pc + 32'd4});
            m_pc = m_pc + 32'd4;
            step();
            n_tests++;
            if (valid !== 1'b1 || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL seq_valid[%0d] got %b want 1", i, valid);
            end else begin
                e = exp_q.pop_front();
                if ({instr, pc4} !== e) begin
                    n_fail++;
                    $display("FAIL seq_data[%0d] got %h/%h want %h/%h",
                             i, instr, pc4, e[63:32], e[31:0]);
                end
            end
        end
    endtask

    task automatic test_ready_gap();
        do_reset();
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            mem_ready = 1'b0;
            step();
            n_tests++;
            if (valid !== 1'b0 || instr !== 32'h0 || bus.IMem_Addr !== 32'h8) begin
                n_fail++;
                $display("FAIL gap_bubble[%0d] got v=%b i=%h a=%h want 0 0 8",
                         i, valid, instr, bus.IMem_Addr);
            end
        end
        mem_ready = 1'b1;
        exp_q.push_back({32'h8, 32'hC});
        step();
        n_tests++;
        if (valid !== 1'b1 || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL gap_resume_valid got %b want 1", valid);
        end else begin
            e = exp_q.pop_front();
            if ({instr, pc4} !== e || bus.IMem_Addr !== 32'hC) begin
                n_fail++;
                $display("FAIL gap_resume got %h/%h a=%h want %h/%h a=0000000c",
                         instr, pc4, bus.IMem_Addr, e[63:32], e[31:0]);
            end
        end
    endtask

    task automatic test_stall();
        exp_q.push_back({32'hC, 32'h10});
        step();
        e = exp_q.pop_front();
        n_tests++;
        if ({instr, pc4} !== e || bus.IMem_Addr !== 32'h10) begin
            n_fail++;
            $display("FAIL stall_pre got %h/%h a=%h want %h/%h a=00000010",
                     instr, pc4, bus.IMem_Addr, e[63:32], e[31:0]);
        end
        Stall = 1'b1;
        exp_q.push_back({32'h10, 32'h14});
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (bus.IMem_Req !== 1'b0 || valid !== 1'b1 ||
                instr !== 32'hC || pc4 !== 32'h10) begin
                n_fail++;
                $display("FAIL stall_frozen[%0d] got req=%b v=%b %h/%h want 0 1 c/10",
                         i, bus.IMem_Req, valid, instr, pc4);
            end
        end
        Stall = 1'b0;
        step();
        n_tests++;
        if (valid !== 1'b1 || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL stall_release_valid got %b want 1", valid);
        end else begin
            e = exp_q.pop_front();
            if ({instr, pc4} !== e || bus.IMem_Addr !== 32'h14 || bus.IMem_Req !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_release got %h/%h a=%h r=%b want %h/%h a=00000014 r=1",
                         instr, pc4, bus.IMem_Addr, bus.IMem_Req, e[63:32], e[31:0]);
            end
        end
    endtask

    task automatic test_branch_hold();
        Stall = 1'b1;
        step();
        Branch_Taken = 1'b1;
        Branch_Target = 32'h0000_0103;
        step();
        Branch_Taken = 1'b0;
        n_tests++;
        if (flush !== 1'b1 || valid !== 1'b0 || instr !== 32'h0 || pc4 !== 32'h0 ||
            bus.IMem_Addr !== 32'h100 || bus.IMem_Req !== 1'b1) begin
            n_fail++;
            $display("FAIL branch_hold got f=%b v=%b %h/%h a=%h r=%b want 1 0 0/0 100 1",
                     flush, valid, instr, pc4, bus.IMem_Addr, bus.IMem_Req);
        end
        Stall = 1'b0;
        exp_q.push_back({32'h100, 32'h104});
        step();
        n_tests++;
        if (flush !== 1'b0 || valid !== 1'b1 || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL branch_after got f=%b v=%b want 0 1", flush, valid);
        end else begin
            e = exp_q.pop_front();
            if ({instr, pc4} !== e) begin
                n_fail++;
                $display("FAIL branch_after_data got %h/%h want %h/%h",
                         instr, pc4, e[63:32], e[31:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        Branch_Taken = 1'b1;
        Branch_Target = 32'h0000_0200;
        step();
        Branch_Target = 32'h0000_0306;
        step();
        n_tests++;
        if (flush !== 1'b1 || valid !== 1'b0 || bus.IMem_Addr !== 32'h304) begin
            n_fail++;
            $display("FAIL b2b_branch got f=%b v=%b a=%h want 1 0 00000304",
                     flush, valid, bus.IMem_Addr);
        end
        Branch_Taken = 1'b0;
        exp_q.push_back({32'h304, 32'h308});
        step();
        n_tests++;
        if (flush !== 1'b0 || valid !== 1'b1 || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL b2b_after got f=%b v=%b want 0 1", flush, valid);
        end else begin
            e = exp_q.pop_front();
            if ({instr, pc4} !== e) begin
                n_fail++;
                $display("FAIL b2b_data got %h/%h want %h/%h",
                         instr, pc4, e[63:32], e[31:0]);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        n_tests++;
        if (bus_w.IMem_Addr !== 32'hFFFF_FFF8) begin
            n_fail++;
            $display("FAIL wrap_start got %h want fffffff8", bus_w.IMem_Addr);
        end
        exp_q.push_back({32'hFFFF_FFF8, 32'hFFFF_FFFC});
        exp_q.push_back({32'hFFFF_FFFC, 32'h0000_0000});
        for (int i = 0; i < 2; i++) begin
            step();
            e = exp_q.pop_front();
            n_tests++;
            if (valid_w !== 1'b1 || {instr_w, pc4_w} !== e) begin
                n_fail++;
                $display("FAIL wrap_data[%0d] got v=%b %h/%h want 1 %h/%h",
                         i, valid_w, instr_w, pc4_w, e[63:32], e[31:0]);
            end
        end
        n_tests++;
        if (bus_w.IMem_Addr !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_addr got %h want 00000000", bus_w.IMem_Addr);
        end
    endtask

    task automatic test_reset_hold();
        do_reset();
        step();
        Stall = 1'b1;
        step();
        #2;
        Reset_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.IMem_Req, valid, flush, instr, pc4} !== 67'd0) begin
            n_fail++;
            $display("FAIL rst_hold_async got req=%b v=%b f=%b %h/%h want all 0",
                     bus.IMem_Req, valid, flush, instr, pc4);
        end
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        Stall = 1'b0;
        step();
        n_tests++;
        if (bus.IMem_Req !== 1'b1 || bus.IMem_Addr !== 32'h0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_hold_restart got r=%b a=%h v=%b want 1 0 0",
                     bus.IMem_Req, bus.IMem_Addr, valid);
        end
        exp_q.push_back({32'h0, 32'h4});
        step();
        e = exp_q.pop_front();
        n_tests++;
        if (valid !== 1'b1 || {instr, pc4} !== e) begin
            n_fail++;
            $display("FAIL rst_hold_first got v=%b %h/%h want 1 %h/%h",
                     valid, instr, pc4, e[63:32], e[31:0]);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_ready_gap();
        test_stall();
        test_branch_hold();
        test_back_to_back();
        test_wrap();
        test_reset_hold();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover got %0d entries want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
